// File: rtl/zepto_fetch.sv
// rtl/zepto_fetch.sv - instruction fetch sequencer for the ZeptoProcessador core
// Optional wait timeout with sticky fetch_err: define ZEPTO_FETCH_TIMEOUT_EN.
module zepto_fetch #(
  parameter int WIDTH   = 16,
  parameter int INC     = 1,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] pc_in,
  output logic [WIDTH-1:0] next_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  output logic             fetch_err
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;

  state_t           state;
  logic             flush;
  logic [WIDTH-1:0] flush_pc;
  logic             timeout_hit;

`ifdef ZEPTO_FETCH_TIMEOUT_EN
  logic [7:0] wait_cnt;
  // An ack arriving on the timeout cycle completes normally, so the timeout requires no ack.
  assign timeout_hit = (state == S_WAIT) && !imem_ack && (wait_cnt == 8'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
  assign fetch_err      = 1'b0;
`endif

  always_comb begin
    next_pc = pc_in;
    if (Reset) begin
      next_pc = '0;
    end else begin
      case (state)
        S_FETCH: if (redirect_valid) next_pc = redirect_target;
        S_WAIT: begin
          // Leaving WAIT without delivering data must still honour any pending redirect.
          if (imem_ack || timeout_hit) begin
            if (redirect_valid)  next_pc = redirect_target;
            else if (flush)      next_pc = flush_pc;
          end
        end
        S_HOLD: begin
          if (redirect_valid)   next_pc = redirect_target;
          else if (instr_ready) next_pc = pc_in + WIDTH'(INC);
        end
        default: next_pc = pc_in;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state       <= S_FETCH;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      flush       <= 1'b0;
      flush_pc    <= '0;
`ifdef ZEPTO_FETCH_TIMEOUT_EN
      wait_cnt    <= '0;
      fetch_err   <= 1'b0;
`endif
    end else begin
      case (state)
        S_FETCH: begin
          if (!redirect_valid) begin
            imem_req  <= 1'b1;
            imem_addr <= pc_in;
            state     <= S_WAIT;
`ifdef ZEPTO_FETCH_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            flush    <= 1'b0;
            if (!redirect_valid && !flush) begin
              instr       <= imem_rdata;
              instr_pc    <= imem_addr;
              instr_valid <= 1'b1;
              state       <= S_HOLD;
            end else begin
              state <= S_FETCH;
            end
          end else begin
            if (redirect_valid) begin
              flush    <= 1'b1;
              flush_pc <= redirect_target;
            end
`ifdef ZEPTO_FETCH_TIMEOUT_EN
            wait_cnt <= wait_cnt + 8'd1;
`endif
            if (timeout_hit) begin
              imem_req <= 1'b0;
              flush    <= 1'b0;
              state    <= S_FETCH;
`ifdef ZEPTO_FETCH_TIMEOUT_EN
              fetch_err <= 1'b1;
`endif
            end
          end
        end
        S_HOLD: begin
          if (redirect_valid || instr_ready) begin
            instr_valid <= 1'b0;
            state       <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_zepto_fetch.sv
// tb/tb_zepto_fetch.sv - directed vector bench for zepto_fetch
// Checks the ZEPTO_FETCH_TIMEOUT_EN behaviour when that macro is defined.
module tb_zepto_fetch;
  logic        clk = 1'b0;
  logic        Reset;
  logic [15:0] pc;
  logic [15:0] next_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic        fetch_err;

  int tests = 0;
  int fails = 0;

`ifdef ZEPTO_FETCH_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  zepto_fetch #(.WIDTH(16), .INC(1), .TIMEOUT(4)) dut (
    .clk(clk), .Reset(Reset), .pc_in(pc), .next_pc(next_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // The pc register the block feeds
  always @(posedge clk) pc <= next_pc;

  typedef struct {
    logic        rv;
    logic [15:0] rt;
    logic        ack;
    logic [15:0] rdata;
    logic        rdy;
    logic [15:0] e_npc;
    logic        e_req;
    logic [15:0] e_addr;
    logic [15:0] e_instr;
    logic [15:0] e_ipc;
    logic        e_val;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic rv, input logic [15:0] rt, input logic ack,
                        input logic [15:0] rdata, input logic rdy);
    redirect_valid  = rv;
    redirect_target = rt;
    imem_ack        = ack;
    imem_rdata      = rdata;
    instr_ready     = rdy;
  endtask

  initial begin
    //            rv  rt       ack rdata    rdy npc      req addr     instr    ipc      val
    vecs[0]  = '{0, 16'h0,   0, 16'h0,    1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0};
    vecs[1]  = '{0, 16'h0,   1, 16'hA5A5, 1, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0};
    vecs[2]  = '{0, 16'h0,   0, 16'h0,    1, 16'h0001, 0, 16'h0000, 16'hA5A5, 16'h0000, 1};
    vecs[3]  = '{0, 16'h0,   0, 16'h0,    1, 16'h0001, 0, 16'h0000, 16'hA5A5, 16'h0000, 0};
    vecs[4]  = '{0, 16'h0,   1, 16'h1111, 0, 16'h0001, 1, 16'h0001, 16'hA5A5, 16'h0000, 0};
    vecs[5]  = '{0, 16'h0,   0, 16'h0,    0, 16'h0001, 0, 16'h0001, 16'h1111, 16'h0001, 1};
    vecs[6]  = '{0, 16'h0,   0, 16'h0,    0, 16'h0001, 0, 16'h0001, 16'h1111, 16'h0001, 1};
    vecs[7]  = '{0, 16'h0,   0, 16'h0,    0, 16'h0001, 0, 16'h0001, 16'h1111, 16'h0001, 1};
    vecs[8]  = '{0, 16'h0,   0, 16'h0,    0, 16'h0001, 0, 16'h0001, 16'h1111, 16'h0001, 1};
    vecs[9]  = '{0, 16'h0,   0, 16'h0,    1, 16'h0002, 0, 16'h0001, 16'h1111, 16'h0001, 1};
    vecs[10] = '{0, 16'h0,   0, 16'h0,    1, 16'h0002, 0, 16'h0001, 16'h1111, 16'h0001, 0};
    vecs[11] = '{1, 16'h40,  0, 16'h0,    1, 16'h0002, 1, 16'h0002, 16'h1111, 16'h0001, 0};
    vecs[12] = '{0, 16'h0,   0, 16'h0,    1, 16'h0002, 1, 16'h0002, 16'h1111, 16'h0001, 0};
    vecs[13] = '{0, 16'h0,   0, 16'h0,    1, 16'h0002, 1, 16'h0002, 16'h1111, 16'h0001, 0};
    vecs[14] = '{0, 16'h0,   1, 16'h1234, 1, 16'h0040, 1, 16'h0002, 16'h1111, 16'h0001, 0};
    vecs[15] = '{0, 16'h0,   0, 16'h0,    1, 16'h0040, 0, 16'h0002, 16'h1111, 16'h0001, 0};
    vecs[16] = '{0, 16'h0,   1, 16'hBEEF, 1, 16'h0040, 1, 16'h0040, 16'h1111, 16'h0001, 0};
    vecs[17] = '{1, 16'h100, 0, 16'h0,    1, 16'h0100, 0, 16'h0040, 16'hBEEF, 16'h0040, 1};
    vecs[18] = '{1, 16'h200, 0, 16'h0,    1, 16'h0200, 0, 16'h0040, 16'hBEEF, 16'h0040, 0};
    vecs[19] = '{0, 16'h0,   0, 16'h0,    1, 16'h0200, 0, 16'h0040, 16'hBEEF, 16'h0040, 0};
    vecs[20] = '{1, 16'h300, 1, 16'hDEAD, 1, 16'h0300, 1, 16'h0200, 16'hBEEF, 16'h0040, 0};
    vecs[21] = '{0, 16'h0,   0, 16'h0,    1, 16'h0300, 0, 16'h0200, 16'hBEEF, 16'h0040, 0};
    vecs[22] = '{0, 16'h0,   1, 16'h5A5A, 1, 16'h0300, 1, 16'h0300, 16'hBEEF, 16'h0040, 0};
    vecs[23] = '{0, 16'h0,   0, 16'h0,    1, 16'h0301, 0, 16'h0300, 16'h5A5A, 16'h0300, 1};

    Reset = 1'b1;
    set_in(0, 16'h0, 0, 16'h0, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_npc",   next_pc,     16'h0);
    check("rst_req",   {15'b0, imem_req},    16'h0);
    check("rst_addr",  imem_addr,   16'h0);
    check("rst_instr", instr,       16'h0);
    check("rst_ipc",   instr_pc,    16'h0);
    check("rst_valid", {15'b0, instr_valid}, 16'h0);
    check("rst_err",   {15'b0, fetch_err},   16'h0);
    @(posedge clk); #1;
    Reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      set_in(vecs[i].rv, vecs[i].rt, vecs[i].ack, vecs[i].rdata, vecs[i].rdy);
      @(negedge clk);
      check($sformatf("v%0d_npc", i),   next_pc,  vecs[i].e_npc);
      check($sformatf("v%0d_req", i),   {15'b0, imem_req},    {15'b0, vecs[i].e_req});
      check($sformatf("v%0d_valid", i), {15'b0, instr_valid}, {15'b0, vecs[i].e_val});
      check($sformatf("v%0d_instr", i), instr,    vecs[i].e_instr);
      check($sformatf("v%0d_ipc", i),   instr_pc, vecs[i].e_ipc);
      check($sformatf("v%0d_err", i),   {15'b0, fetch_err},   16'h0);
      if (vecs[i].e_req) check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
      @(posedge clk); #1;
    end

    // PC wrap: redirect to 0xFFFF, fetch it, accept it
    set_in(1, 16'hFFFF, 0, 16'h0, 1);
    @(negedge clk); check("wrap_redir_npc", next_pc, 16'hFFFF);
    @(posedge clk); #1;
    set_in(0, 16'h0, 0, 16'h0, 1);
    @(posedge clk); #1;
    set_in(0, 16'h0, 1, 16'h7777, 1);
    @(negedge clk); check("wrap_addr", imem_addr, 16'hFFFF);
    @(posedge clk); #1;
    set_in(0, 16'h0, 0, 16'h0, 1);
    @(negedge clk);
    check("wrap_ipc", instr_pc, 16'hFFFF);
    check("wrap_npc", next_pc,  16'h0000);
    @(posedge clk); #1;

    // Reset while in WAIT, ack arriving the cycle after
    instr_ready = 1'b0;
    @(posedge clk); #1;
    Reset = 1'b1;
    @(negedge clk); check("rstw_npc", next_pc, 16'h0);
    @(posedge clk); #1;
    Reset = 1'b0;
    set_in(0, 16'h0, 1, 16'h9999, 0);
    @(negedge clk);
    check("rstw_req",   {15'b0, imem_req},    16'h0);
    check("rstw_valid", {15'b0, instr_valid}, 16'h0);
    check("rstw_instr", instr, 16'h0);
    @(posedge clk); #1;
    imem_ack = 1'b0;

    // Four WAIT cycles without ack, then timeout or continued wait
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("to_w%0d_req", k), {15'b0, imem_req},    16'h1);
      check($sformatf("to_w%0d_err", k), {15'b0, fetch_err},   16'h0);
      check($sformatf("to_w%0d_val", k), {15'b0, instr_valid}, 16'h0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("to_req_drop", {15'b0, imem_req},  {15'b0, ~TO_EN});
    check("to_err",      {15'b0, fetch_err}, {15'b0, TO_EN});
    @(posedge clk); #1;
    @(negedge clk);
    check("to_refetch_req",  {15'b0, imem_req},  16'h1);
    check("to_refetch_addr", imem_addr, 16'h0000);
    check("to_err_sticky",   {15'b0, fetch_err}, {15'b0, TO_EN});
    set_in(0, 16'h0, 1, 16'h4321, 0);
    @(posedge clk); #1;
    imem_ack = 1'b0;
    @(negedge clk);
    check("to_done_valid", {15'b0, instr_valid}, 16'h1);
    check("to_done_instr", instr, 16'h4321);
    check("to_done_err",   {15'b0, fetch_err}, {15'b0, TO_EN});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
